// File: rtl/jump_branch_seq.sv
// Control-step sequencer for br, jr and jal: drives the fetch steps (T0-T2)
// and the execute steps, one control step per clock.
module jump_branch_seq #(
  parameter int unsigned    OPW      = 5,
  parameter logic [OPW-1:0] OP_BR    = 5'b10010,
  parameter logic [OPW-1:0] OP_JAL   = 5'b10011,
  parameter logic [OPW-1:0] OP_JR    = 5'b10100,
  parameter int unsigned    MEM_WAIT = 1,
  parameter int unsigned    NUM_REGS = 16,
  parameter int unsigned    LINK_REG = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                CON,
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                memRead,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Rout,
  output logic                PCin,
  output logic                CONin,
  output logic                Cout,
  output logic                Yin,
  output logic                ADD,
  output logic                Zin,
  output logic                Zlowout,
  output logic [NUM_REGS-1:0] link_in,
  output logic                done,
  output logic                illegal,
  output logic                busy
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StDec,
    StJr3, StJal3, StJal4,
    StBr3, StBr4, StBr5, StBr6,
    StIll
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [OPW-1:0] opcode;

  assign opcode = ir[31 -: OPW];

  // Only the opcode field is decoded; the rest of ir belongs to the datapath.
  logic unused_ir;
  assign unused_ir = ^ir;

  // State and wait-counter registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (run) state_d = StT0;
      StT0: begin
        state_d = StT1;
        cnt_d   = 4'(MEM_WAIT - 1);
      end
      StT1: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = StT2;
      end
      StT2:  state_d = StDec;
      StDec: begin
        if (opcode == OP_JR)       state_d = StJr3;
        else if (opcode == OP_JAL) state_d = StJal3;
        else if (opcode == OP_BR)  state_d = StBr3;
        else                       state_d = StIll;
      end
      StJal3: state_d = StJal4;
      StBr3:  state_d = StBr4;
      StBr4:  state_d = StBr5;
      StBr5:  state_d = StBr6;
      // Final steps chain straight into the next fetch while run is held.
      StJr3, StJal4, StBr6: state_d = run ? StT0 : StIdle;
      StIll:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    memRead = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Rout    = 1'b0;
    PCin    = 1'b0;
    CONin   = 1'b0;
    Cout    = 1'b0;
    Yin     = 1'b0;
    ADD     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    link_in = '0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      StT1: begin
        memRead = 1'b1;
        MDRin   = (cnt_q == 4'd0);
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StJr3, StJal4: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        PCin = 1'b1;
        done = 1'b1;
      end
      StJal3: begin
        PCout             = 1'b1;
        link_in[LINK_REG] = 1'b1;
      end
      StBr3: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        CONin = 1'b1;
      end
      StBr4: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      StBr5: begin
        Cout = 1'b1;
        ADD  = 1'b1;
        Zin  = 1'b1;
      end
      StBr6: begin
        Zlowout = 1'b1;
        // CON was latched in BR3, so it is stable by now.
        PCin    = CON;
        done    = 1'b1;
      end
      StIll:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jump_branch_seq.sv
// Bench for jump_branch_seq: one instance (MEM_WAIT=1) runs a small datapath
// model for end-to-end PC/link checks, a second (MEM_WAIT=3) runs alongside.
module tb_jump_branch_seq;

  localparam int unsigned MW3 = 3;
  localparam logic [4:0] OpBr  = 5'b10010;
  localparam logic [4:0] OpJal = 5'b10011;
  localparam logic [4:0] OpJr  = 5'b10100;

  // Observation word bit positions.
  localparam int WPcout = 20, WIncpc = 19, WMarin = 18, WMemrd = 17, WMdrin = 16;
  localparam int WMdrout = 15, WIrin = 14, WGra = 13, WRout = 12, WPcin = 11;
  localparam int WConin = 10, WCout = 9, WYin = 8, WAdd = 7, WZin = 6, WZlow = 5;
  localparam int WLink = 4, WLinkOther = 3, WDone = 2, WIll = 1, WBusy = 0;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir3 = '0;
  logic        con3 = 1'b0;

  logic [18:0] c1, c3;
  logic [15:0] link1, link3;
  logic [20:0] w1, w3;

  assign w1 = {c1[18:3], link1[15], |link1[14:0], c1[2:0]};
  assign w3 = {c3[18:3], link3[15], |link3[14:0], c3[2:0]};

  // Datapath model around the first instance.
  logic [31:0] pc = '0, mar = '0, mdr = '0, ir_q = '0, y = '0, z = '0, r15 = '0;
  logic        con_ff = 1'b0;
  logic [31:0] mem  [0:255];
  logic [31:0] regs [0:15];
  logic        ld_en = 1'b0;
  logic [31:0] ld_pc = '0;
  logic [31:0] bus, rval, csx;
  logic [3:0]  ra;
  logic        cond;

  assign ra   = ir_q[26:23];
  assign rval = (ra == 4'd15) ? r15 : regs[ra];
  assign csx  = {{13{ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    bus = '0;
    if (c1[18])      bus = pc;
    else if (c1[10]) bus = rval;
    else if (c1[13]) bus = mdr;
    else if (c1[3])  bus = z;
    else if (c1[7])  bus = csx;
  end

  always_comb begin
    cond = 1'b0;
    case (ir_q[20:19])
      2'd0: cond = (rval == 32'd0);
      2'd1: cond = (rval != 32'd0);
      2'd2: cond = !rval[31];
      default: cond = rval[31];
    endcase
  end

  always @(posedge clock) begin
    if (ld_en) pc <= ld_pc;
    else begin
      if (c1[17]) pc <= pc + 32'd1;
      if (c1[9])  pc <= bus;
    end
    if (c1[16]) mar <= bus;
    if (c1[15] && c1[14]) mdr <= mem[mar[7:0]];
    if (c1[12]) ir_q <= bus;
    if (link1[15]) r15 <= bus;
    if (c1[6]) y <= bus;
    if (c1[4]) z <= c1[5] ? y + bus : bus;
    if (c1[8]) con_ff <= cond;
  end

  jump_branch_seq #(.MEM_WAIT(1)) dut1 (
    .clock(clock), .clear(clear), .run(run), .ir(ir_q), .CON(con_ff),
    .PCout(c1[18]), .IncPC(c1[17]), .MARin(c1[16]), .memRead(c1[15]), .MDRin(c1[14]),
    .MDRout(c1[13]), .IRin(c1[12]), .Gra(c1[11]), .Rout(c1[10]), .PCin(c1[9]),
    .CONin(c1[8]), .Cout(c1[7]), .Yin(c1[6]), .ADD(c1[5]), .Zin(c1[4]),
    .Zlowout(c1[3]), .link_in(link1), .done(c1[2]), .illegal(c1[1]), .busy(c1[0])
  );

  jump_branch_seq #(.MEM_WAIT(MW3)) dut3 (
    .clock(clock), .clear(clear), .run(run), .ir(ir3), .CON(con3),
    .PCout(c3[18]), .IncPC(c3[17]), .MARin(c3[16]), .memRead(c3[15]), .MDRin(c3[14]),
    .MDRout(c3[13]), .IRin(c3[12]), .Gra(c3[11]), .Rout(c3[10]), .PCin(c3[9]),
    .CONin(c3[8]), .Cout(c3[7]), .Yin(c3[6]), .ADD(c3[5]), .Zin(c3[4]),
    .Zlowout(c3[3]), .link_in(link3), .done(c3[2]), .illegal(c3[1]), .busy(c3[0])
  );

  initial forever #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [20:0] obs1 [0:31];
  logic [20:0] obs3 [0:31];
  logic [20:0] exp1 [0:31];
  logic [20:0] exp3 [0:31];
  bit          runv [0:31];

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [4:0] op);
    return (op == OpBr) || (op == OpJal) || (op == OpJr);
  endfunction

  function automatic int oplen(input logic [4:0] op);
    if (op == OpBr)  return 4;
    if (op == OpJal) return 2;
    return 1;
  endfunction

  // Expected control word for step k of an instruction (k=0 is T0).
  function automatic logic [20:0] word(input logic [4:0] op, input int mw, input bit con,
                                       input int k);
    logic [20:0] w;
    int e;
    w = '0;
    w[WBusy] = 1'b1;
    if (k == 0) begin
      w[WPcout] = 1'b1; w[WIncpc] = 1'b1; w[WMarin] = 1'b1;
    end else if (k <= mw) begin
      w[WMemrd] = 1'b1;
      w[WMdrin] = (k == mw);
    end else if (k == mw + 1) begin
      w[WMdrout] = 1'b1; w[WIrin] = 1'b1;
    end else if (k > mw + 2) begin
      e = k - mw - 3;
      if (op == OpJr || (op == OpJal && e == 1)) begin
        w[WGra] = 1'b1; w[WRout] = 1'b1; w[WPcin] = 1'b1; w[WDone] = 1'b1;
      end else if (op == OpJal) begin
        w[WPcout] = 1'b1; w[WLink] = 1'b1;
      end else if (op == OpBr) begin
        case (e)
          0: begin w[WGra] = 1'b1; w[WRout] = 1'b1; w[WConin] = 1'b1; end
          1: begin w[WPcout] = 1'b1; w[WYin] = 1'b1; end
          2: begin w[WCout] = 1'b1; w[WAdd] = 1'b1; w[WZin] = 1'b1; end
          default: begin w[WZlow] = 1'b1; w[WPcin] = con; w[WDone] = 1'b1; end
        endcase
      end else begin
        w[WIll] = 1'b1;
      end
    end
    return w;
  endfunction

  // Expected window given the recorded run trace; first edge always starts.
  task automatic model(input logic [4:0] op, input int mw, input bit con, input int n,
                       input bit sel);
    int k, tot;
    bit act;
    logic [20:0] e;
    tot = mw + 3 + oplen(op);
    act = 1'b1;
    k = 0;
    for (int i = 0; i < n; i++) begin
      e = act ? word(op, mw, con, k) : 21'd0;
      if (sel) exp3[i] = e;
      else     exp1[i] = e;
      if (!act) begin
        if (runv[i]) begin act = 1'b1; k = 0; end
      end else if (k == tot - 1) begin
        if (runv[i] && legal(op)) k = 0;
        else act = 1'b0;
      end else begin
        k++;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_pc(input logic [31:0] v);
    @(negedge clock);
    ld_pc = v;
    ld_en = 1'b1;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Start from idle, record n cycles; run stays high through capture index hold-1.
  task automatic apply(input int n, input int hold);
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs1[i] = w1;
      obs3[i] = w3;
      run = (i < hold);
      runv[i] = run;
    end
  endtask

  task automatic drain(input string name);
    int t;
    run = 1'b0;
    t = 0;
    while ((w1[WBusy] || w3[WBusy]) && t < 40) begin
      @(negedge clock);
      t++;
    end
    vectors++;
    if (w1[WBusy] || w3[WBusy]) begin
      miscompares++;
      $display("FAIL %s drain: busy=%b%b, want 00", name, w1[WBusy], w3[WBusy]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] ins;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (w1 !== 21'd0 || w3 !== 21'd0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: got %h/%h want 0/0", i, w1, w3);
      end
    end
    clear = 1'b0;
    ins = {OpBr, 4'd3, 4'd0, 19'd5};
    regs[3] = 32'd0;
    mem[8'h10] = ins;
    ir3 = ins;
    con3 = 1'b1;
    set_pc(32'h10);
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      obs1[i] = w1;
    end
    vectors++;
    if (obs1[6] !== word(OpBr, 1, 1'b1, 6)) begin
      miscompares++;
      $display("FAIL reset_br5_reached: got %h want %h", obs1[6], word(OpBr, 1, 1'b1, 6));
    end
    clear = 1'b1;
    @(negedge clock);
    vectors++;
    if (w1 !== 21'd0 || w3 !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_mid_br5: got %h/%h want 0/0", w1, w3);
    end
    clear = 1'b0;
    run = 1'b0;
    @(negedge clock);
    vectors++;
    if (w1 !== 21'd0 || w3 !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_stay_idle: got %h/%h want 0/0", w1, w3);
    end
    run = 1'b1;
    @(negedge clock);
    vectors++;
    if (w1 !== word(OpBr, 1, 1'b0, 0) || w3 !== word(OpBr, MW3, 1'b0, 0)) begin
      miscompares++;
      $display("FAIL reset_restart_t0: got %h/%h want %h", w1, w3, word(OpBr, 1, 1'b0, 0));
    end
    drain("reset");
  endtask

  task automatic test_jr();
    regs[6] = 32'h100;
    mem[8'h20] = 32'hA3000000;
    ir3 = 32'hA3000000;
    set_pc(32'h20);
    apply(9, 0);
    model(OpJr, 1, 1'b0, 9, 1'b0);
    model(OpJr, MW3, 1'b0, 9, 1'b1);
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (obs1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL jr mw1 cycle %0d: got %h want %h", i, obs1[i], exp1[i]);
      end
      vectors++;
      if (obs3[i] !== exp3[i]) begin
        miscompares++;
        $display("FAIL jr mw3 cycle %0d: got %h want %h", i, obs3[i], exp3[i]);
      end
    end
    drain("jr");
    vectors++;
    if (pc !== 32'h100) begin
      miscompares++;
      $display("FAIL jr_pc: got %h want %h", pc, 32'h100);
    end
  endtask

  task automatic test_jal();
    logic [31:0] tgt;
    tgt = $urandom;
    regs[6] = tgt;
    mem[8'h20] = 32'h9B000000;
    ir3 = 32'h9B000000;
    set_pc(32'h20);
    apply(10, 0);
    model(OpJal, 1, 1'b0, 10, 1'b0);
    model(OpJal, MW3, 1'b0, 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (obs1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL jal mw1 cycle %0d: got %h want %h", i, obs1[i], exp1[i]);
      end
      vectors++;
      if (obs3[i] !== exp3[i]) begin
        miscompares++;
        $display("FAIL jal mw3 cycle %0d: got %h want %h", i, obs3[i], exp3[i]);
      end
    end
    drain("jal");
    vectors++;
    if (r15 !== 32'h21 || pc !== tgt) begin
      miscompares++;
      $display("FAIL jal_link_pc: got r15=%h pc=%h want r15=%h pc=%h", r15, pc, 32'h21, tgt);
    end
  endtask

  task automatic test_br();
    logic [31:0] ins, rv, pc0, want;
    logic [18:0] c19;
    logic [3:0]  rr;
    logic [1:0]  cc;
    bit          taken;
    for (int it = 0; it < 6; it++) begin
      rr  = 4'($urandom_range(1, 14));
      cc  = (it < 2) ? 2'd0 : 2'($urandom_range(0, 3));
      c19 = 19'($urandom);
      pc0 = 32'($urandom_range(0, 150));
      case (it == 0 ? 0 : it == 1 ? 1 : $urandom_range(0, 3))
        0: rv = 32'd0;
        1: rv = 32'd7;
        2: rv = 32'hFFFF_FFF0;
        default: rv = $urandom;
      endcase
      case (cc)
        2'd0: taken = (rv == 32'd0);
        2'd1: taken = (rv != 32'd0);
        2'd2: taken = ($signed(rv) >= 0);
        default: taken = ($signed(rv) < 0);
      endcase
      want = taken ? pc0 + 32'd1 + {{13{c19[18]}}, c19} : pc0 + 32'd1;
      ins = {OpBr, rr, 2'b00, cc, c19};
      regs[rr] = rv;
      mem[pc0[7:0]] = ins;
      ir3 = ins;
      con3 = taken;
      set_pc(pc0);
      apply(12, 0);
      model(OpBr, 1, taken, 12, 1'b0);
      model(OpBr, MW3, taken, 12, 1'b1);
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if (obs1[i] !== exp1[i]) begin
          miscompares++;
          $display("FAIL br%0d mw1 cycle %0d: got %h want %h", it, i, obs1[i], exp1[i]);
        end
        vectors++;
        if (obs3[i] !== exp3[i]) begin
          miscompares++;
          $display("FAIL br%0d mw3 cycle %0d: got %h want %h", it, i, obs3[i], exp3[i]);
        end
      end
      drain("br");
      vectors++;
      if (pc !== want) begin
        miscompares++;
        $display("FAIL br%0d_pc taken=%0d: got %h want %h", it, taken, pc, want);
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0]  op;
    logic [31:0] ins, pc0;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) ins = 32'h0;
      else begin
        do op = 5'($urandom); while (legal(op));
        ins = {op, 27'($urandom)};
      end
      op = ins[31:27];
      pc0 = 32'($urandom_range(0, 150));
      mem[pc0[7:0]] = ins;
      ir3 = ins;
      set_pc(pc0);
      apply(9, 0);
      model(op, 1, 1'b0, 9, 1'b0);
      model(op, MW3, 1'b0, 9, 1'b1);
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (obs1[i] !== exp1[i]) begin
          miscompares++;
          $display("FAIL ill%0d mw1 cycle %0d: got %h want %h", it, i, obs1[i], exp1[i]);
        end
        vectors++;
        if (obs3[i] !== exp3[i]) begin
          miscompares++;
          $display("FAIL ill%0d mw3 cycle %0d: got %h want %h", it, i, obs3[i], exp3[i]);
        end
      end
      drain("illegal");
      vectors++;
      if (pc !== pc0 + 32'd1) begin
        miscompares++;
        $display("FAIL ill%0d_pc: got %h want %h", it, pc, pc0 + 32'd1);
      end
    end
  endtask

  task automatic test_back_to_back();
    regs[6] = 32'h40;
    regs[7] = 32'h50;
    mem[8'h30] = 32'hA3000000;
    mem[8'h40] = 32'hA3800000;
    ir3 = 32'hA3000000;
    set_pc(32'h30);
    apply(16, 9);
    model(OpJr, 1, 1'b0, 16, 1'b0);
    model(OpJr, MW3, 1'b0, 16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (obs1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL b2b mw1 cycle %0d: got %h want %h", i, obs1[i], exp1[i]);
      end
      vectors++;
      if (obs3[i] !== exp3[i]) begin
        miscompares++;
        $display("FAIL b2b mw3 cycle %0d: got %h want %h", i, obs3[i], exp3[i]);
      end
    end
    drain("b2b");
    vectors++;
    if (pc !== 32'h50) begin
      miscompares++;
      $display("FAIL b2b_pc: got %h want %h", pc, 32'h50);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    test_reset();
    test_jr();
    test_jal();
    test_br();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
